// File: rtl/detector_scheduler_pkg.sv
// Shared widths and helpers for the K-best detector front-end sequencer.
package detector_scheduler_pkg;

    localparam int WL      = 15;
    localparam int R_ELEMS = 36;
    localparam int Y_ELEMS = 8;
    localparam int X_W     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/det_out_fifo.sv
// First-word-fall-through result FIFO; a push on a full FIFO is legal only alongside a pop.
module det_out_fifo
    import detector_scheduler_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [clog2(DEPTH):0]    count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign count     = count_reg;
    assign do_pop    = pop & ~empty;
    // Head is forced to zero while empty so stale storage never leaks onto x_data.
    assign head_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !do_pop));

endmodule

// File: rtl/detector_scheduler.sv
// Feeds R/Y into the non-stallable detector, tags vectors in flight and buffers
// detected X under a credit limit so downstream backpressure never loses a result.
module detector_scheduler
    import detector_scheduler_pkg::*;
#(
    parameter int WL      = detector_scheduler_pkg::WL,
    parameter int DET_LAT = 32,
    parameter int DEPTH   = 8
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [R_ELEMS*WL-1:0]   r_data,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [Y_ELEMS*WL-1:0]   y_data,
    input  logic                    y_valid,
    input  logic                    y_last,
    output logic                    y_ready,
    output logic [R_ELEMS*WL-1:0]   det_rmat,
    output logic [Y_ELEMS*WL-1:0]   det_yarr,
    input  logic [X_W-1:0]          det_x,
    output logic [X_W-1:0]          x_data,
    output logic                    x_last,
    output logic                    x_valid,
    input  logic                    x_ready,
    output logic                    busy
);
    localparam int CW = clog2(DEPTH) + 1;

    sched_state_t            state_reg, state_next;
    logic                    alive_reg;
    logic [R_ELEMS*WL-1:0]   rmat_reg;
    logic                    issue_reg, issue_last_reg;
    logic [DET_LAT-1:0]      tag_v_reg, tag_last_reg;
    logic [CW-1:0]           inflight_reg;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             credit_sum;
    logic                    credit_ok, r_fire, y_fire, tag_exit;
    logic                    fifo_full, fifo_empty;
    logic [X_W:0]            fifo_head;

    // Credits cover both buffered and in-flight results, so y_ready never looks at x_ready.
    assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight_reg};
    assign credit_ok  = (credit_sum < (CW+1)'(DEPTH));
    assign r_ready    = (state_reg == ST_IDLE) & alive_reg;
    assign y_ready    = (state_reg == ST_RUN) & credit_ok;
    assign r_fire     = r_valid & r_ready;
    assign y_fire     = y_valid & y_ready;
    assign tag_exit   = tag_v_reg[DET_LAT-1];
    assign busy       = (state_reg == ST_RUN) | (inflight_reg != '0) | (fifo_count != '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (r_fire) state_next = ST_RUN;
            ST_RUN:  if (y_fire && y_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            alive_reg      <= 1'b0;
            rmat_reg       <= '0;
            det_rmat       <= '0;
            det_yarr       <= '0;
            issue_reg      <= 1'b0;
            issue_last_reg <= 1'b0;
            tag_v_reg      <= '0;
            tag_last_reg   <= '0;
            inflight_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            alive_reg      <= 1'b1;
            issue_reg      <= y_fire;
            issue_last_reg <= y_fire & y_last;
            if (r_fire) begin
                rmat_reg <= r_data;
            end
            if (y_fire) begin
                det_yarr <= y_data;
                det_rmat <= rmat_reg;
            end
            // Tags enter one cycle after det_yarr is registered, aligning the exit with det_x.
            tag_v_reg    <= {tag_v_reg[DET_LAT-2:0], issue_reg};
            tag_last_reg <= {tag_last_reg[DET_LAT-2:0], issue_last_reg};
            case ({y_fire, tag_exit})
                2'b10:   inflight_reg <= inflight_reg + 1'b1;
                2'b01:   inflight_reg <= inflight_reg - 1'b1;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    det_out_fifo #(
        .WIDTH (X_W + 1),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_exit),
        .push_data ({tag_last_reg[DET_LAT-1], det_x}),
        .pop       (x_valid & x_ready),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign x_valid = ~fifo_empty;
    assign x_last  = fifo_head[X_W];
    assign x_data  = fifo_head[X_W-1:0];

endmodule
